// File: rtl/reg_file.sv
// rtl/reg_file.sv - multi-port register file with registered read address and clear engine
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (starts a full clear on release)
//   we       write enable; waddr/wdata write address and data
//   raddr    NRD packed read addresses, port i at [i*AW +: AW]
//   rdata    NRD packed read data, port i at [i*DW +: DW]
//   clr_req  single-cycle request to zero every entry
//   busy     clear engine running; writes dropped, reads return 0
module reg_file #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  input  logic              clr_req,
  output logic              busy
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  // One extra bit so range checks also work when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   raddr_q [NRD];
  logic [DW-1:0]   mem [DEPTH];
  logic            wr_ok;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; clr_req while clearing is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state_q == ST_CLEAR);
  end

  assign wr_ok = !busy && we && ({1'b0, waddr} < DEPTH_L) &&
                 !((ZERO_REG != 0) && (waddr == '0));

  // Storage has no reset; the clear engine owns the single write port while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  // Read addresses latch every edge, independent of busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NRD; i++) raddr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) raddr_q[i] <= raddr[i*AW +: AW];
    end
  end

  // Combinational read from the array at the latched address, so a write at
  // the same edge is visible immediately (write-first).
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!busy && ({1'b0, raddr_q[i]} < DEPTH_L) &&
          !((ZERO_REG != 0) && (raddr_q[i] == '0))) begin
        rdata[i*DW +: DW] = mem[raddr_q[i]];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file (DEPTH=32 zero-reg and DEPTH=20 plain)
module tb_reg_file;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;
  localparam int DA  = 32;
  localparam int DB  = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              we = 1'b0;
  logic              clr_req = 1'b0;
  logic [AW-1:0]     waddr = '0;
  logic [DW-1:0]     wdata = '0;
  logic [NRD*AW-1:0] raddr = '0;
  logic [NRD*DW-1:0] rdata_a, rdata_b;
  logic              busy_a, busy_b;

  reg_file #(.DW(DW), .DEPTH(DA), .NRD(NRD), .ZERO_REG(1)) u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_a), .clr_req(clr_req), .busy(busy_a)
  );

  reg_file #(.DW(DW), .DEPTH(DB), .NRD(NRD), .ZERO_REG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .clr_req(clr_req), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Reference model: contents, remaining busy cycles, latched read addresses.
  logic [DW-1:0] ma [DA];
  logic [DW-1:0] mb [DB];
  int            bl_a, bl_b;
  int            raq [NRD];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bl_a = DA;
    bl_b = DB;
    for (int i = 0; i < NRD; i++) raq[i] = 0;
    for (int i = 0; i < DA; i++) ma[i] = '0;
    for (int i = 0; i < DB; i++) mb[i] = '0;
  endtask

  // While clearing, reads are 0 and writes dropped, so the whole array can be
  // zeroed at the start of a clear without tracking the sweep.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (bl_a > 0) bl_a--;
      else begin
        if (we && int'(waddr) < DA && waddr != 0) ma[waddr] = wdata;
        if (clr_req) begin
          for (int i = 0; i < DA; i++) ma[i] = '0;
          bl_a = DA;
        end
      end
      if (bl_b > 0) bl_b--;
      else begin
        if (we && int'(waddr) < DB) mb[waddr] = wdata;
        if (clr_req) begin
          for (int i = 0; i < DB; i++) mb[i] = '0;
          bl_b = DB;
        end
      end
      for (int i = 0; i < NRD; i++) raq[i] = int'(raddr[i*AW +: AW]);
    end
  endtask

  function automatic logic [DW-1:0] exp_a(input int p);
    if (bl_a > 0 || raq[p] >= DA || raq[p] == 0) return '0;
    return ma[raq[p]];
  endfunction

  function automatic logic [DW-1:0] exp_b(input int p);
    if (bl_b > 0 || raq[p] >= DB) return '0;
    return mb[raq[p]];
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".busy_a"}, 64'(busy_a), 64'(bl_a > 0));
    chk({tag, ".busy_b"}, 64'(busy_b), 64'(bl_b > 0));
    for (int p = 0; p < NRD; p++) begin
      chk($sformatf("%s.a%0d", tag, p), 64'(rdata_a[p*DW +: DW]), 64'(exp_a(p)));
      chk($sformatf("%s.b%0d", tag, p), 64'(rdata_b[p*DW +: DW]), 64'(exp_b(p)));
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic set_ra(input int a0, input int a1);
    raddr = {AW'(a1), AW'(a0)};
  endtask

  task automatic count_busy(input string tag, input int exp_cycles);
    int n;
    n = 0;
    for (int i = 0; i < 60 && busy_a; i++) begin
      we    = 1'b1;
      waddr = AW'($urandom_range(1, 31));
      wdata = $urandom;
      set_ra($urandom_range(0, 31), $urandom_range(0, 31));
      cyc(tag);
      n++;
    end
    we = 1'b0;
    chk({tag, ".busy_len"}, 64'(n), 64'(exp_cycles));
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    cyc("in_reset");
    cyc("in_reset");

    // Release: busy for exactly DEPTH cycles per instance.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DA; i++) begin
      set_ra($urandom_range(0, 31), $urandom_range(0, 31));
      chk("init_busy_a", 64'(busy_a), 64'(1));
      chk("init_busy_b", 64'(busy_b), 64'(i < DB));
      chk("init_rdata_a", 64'(rdata_a), 64'(0));
      cyc("init_clr");
    end
    chk("init_idle_a", 64'(busy_a), 64'(0));

    for (int i = 0; i < DA; i++) begin
      set_ra(i, DA - 1 - i);
      cyc("read_zero");
    end

    // Write-first read of entry 5.
    we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF; set_ra(5, 0);
    cyc("wr5");
    chk("wr5_a0", 64'(rdata_a[DW-1:0]), 64'h0000_0000_DEAD_BEEF);
    chk("wr5_b0", 64'(rdata_b[DW-1:0]), 64'h0000_0000_DEAD_BEEF);
    we = 1'b0; set_ra(0, 5);
    cyc("rd5");
    chk("rd5_a1", 64'(rdata_a[2*DW-1:DW]), 64'h0000_0000_DEAD_BEEF);

    // Entry 0: hardwired zero in A, ordinary storage in B.
    we = 1'b1; waddr = 0; wdata = 32'h12345678; set_ra(0, 0);
    cyc("wr0");
    we = 1'b0;
    cyc("rd0");
    chk("zero_a", 64'(rdata_a), 64'(0));
    chk("zero_b", 64'(rdata_b), {32'h12345678, 32'h12345678});

    // Fill 1..31.
    for (int i = 1; i < DA; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = 32'(i) * 32'h01010101;
      set_ra(i, i - 1);
      cyc("fill");
    end
    we = 1'b0;
    for (int i = 0; i < DA; i++) begin
      set_ra(i, $urandom_range(0, 31));
      cyc("fill_rd");
    end

    // Clear with a second request 3 cycles later: no restart.
    clr_req = 1'b1;
    cyc("clr_pulse");
    clr_req = 1'b0;
    for (int i = 0; i < 2; i++) cyc("clr_wait");
    clr_req = 1'b1;
    cyc("clr_again");
    clr_req = 1'b0;
    count_busy("clr_run", DA - 3);
    for (int i = 0; i < DA; i++) begin
      set_ra(i, DA - 1 - i);
      cyc("after_clr");
    end

    // Out-of-range address on the DEPTH=20 instance.
    we = 1'b1; waddr = 25; wdata = 32'hCAFEF00D; set_ra(25, 19);
    cyc("wr25");
    waddr = 19; wdata = 32'h0BADC0DE;
    cyc("wr19");
    we = 1'b0;
    cyc("rd19");
    chk("oor_b", 64'(rdata_b[DW-1:0]), 64'(0));
    chk("e19_b", 64'(rdata_b[2*DW-1:DW]), 64'h0000_0000_0BAD_C0DE);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      we      = $urandom_range(0, 1);
      waddr   = AW'($urandom);
      wdata   = $urandom;
      clr_req = ($urandom_range(0, 39) == 0);
      set_ra($urandom_range(0, 31), $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) set_ra(waddr, waddr);
      cyc("rand");
    end
    clr_req = 1'b0;
    we = 1'b0;
    for (int i = 0; i < 40 && busy_a; i++) cyc("drain");

    // Reset while idle with live data on the read port.
    we = 1'b1; waddr = 7; wdata = 32'h5A5A5A5A; set_ra(7, 7);
    cyc("pre_rst");
    we = 1'b0;
    chk("pre_rst_a", 64'(rdata_a[DW-1:0]), 64'h0000_0000_5A5A_5A5A);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_idle_busy", 64'(busy_a), 64'(1));
    chk("rst_idle_rdata", 64'(rdata_a), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("rst_idle_run", DA);

    // Reset at clear count 10.
    clr_req = 1'b1;
    cyc("clr2");
    clr_req = 1'b0;
    for (int i = 0; i < 9; i++) cyc("clr2_run");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    chk("rst_mid_busy", 64'(busy_a), 64'(1));
    chk("rst_mid_rdata", 64'(rdata_b), 64'(0));
    cyc("rst_mid_hold");
    @(negedge clk);
    rst_n = 1'b1;
    count_busy("rst_mid_run", DA);
    for (int i = 0; i < DA; i++) begin
      set_ra(i, i);
      cyc("final_rd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
